// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, XLEN+2 cycle latency.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow requests in one cycle.
module divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvsr;
  logic            neg_q;
  logic            neg_r;
  logic            dz;
  logic [CW-1:0]   cnt;

  logic            is_signed;
  logic            op1_neg;
  logic            op2_neg;
  logic            div_zero_in;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] fix_val;

  always_comb begin
    is_signed   = ~div_op[0];
    op1_neg     = is_signed & operand1[XLEN-1];
    op2_neg     = is_signed & operand2[XLEN-1];
    div_zero_in = (operand2 == '0);
    mag1        = op1_neg ? -operand1 : operand1;
    mag2        = op2_neg ? -operand2 : operand2;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr};
    ge     = ~diff[XLEN];
  end

  // A zero divisor must keep the all-ones quotient even when signs differ.
  always_comb begin
    q_fin   = (neg_q && !dz) ? -quo : quo;
    r_fin   = neg_r ? -rem : rem;
    fix_val = op_q[1] ? r_fin : q_fin;
  end

`ifdef DIV_EARLY_OUT_EN
  logic            ovf_in;
  logic            early_in;
  logic [XLEN-1:0] early_res;

  always_comb begin
    ovf_in    = is_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
    early_in  = div_zero_in || ovf_in;
    if (div_op[1]) early_res = div_zero_in ? operand1 : '0;
    else           early_res = div_zero_in ? '1 : operand1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op_q   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
`ifdef DIV_EARLY_OUT_EN
            if (early_in) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= early_res;
            end else
`endif
            begin
              state <= CALC;
              busy  <= 1'b1;
              op_q  <= div_op;
              quo   <= mag1;
              rem   <= '0;
              dvsr  <= mag2;
              neg_q <= ~div_op[1] & (op1_neg ^ op2_neg);
              neg_r <= div_op[1] & op1_neg;
              dz    <= div_zero_in;
              cnt   <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          quo <= {quo[XLEN-2:0], ge};
          rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Randomized scoreboard bench for divider: directed RV32M corner cases, flush, reset and random ops.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_res[$];
  int          exp_cyc[$];
  logic [31:0] last_exp = '0;

  divider #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .div_op(div_op),
    .operand1(operand1), .operand2(operand2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    bit     ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a falling edge; inputs stay for exactly one rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    div_op = op; operand1 = a; operand2 = b; start = 1'b1;
    if (expect_done) begin
      last_exp = model(op, a, b);
      exp_res.push_back(last_exp);
      exp_cyc.push_back(cyc + latency(op, a, b));
    end
    @(negedge clk);
    start = 1'b0; operand1 = $urandom; operand2 = $urandom; div_op = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) check("busy_timeout", 32'(busy), 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_res.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain_empty", 32'(exp_res.size()), 32'h0);
    wait_idle();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_res.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        logic [31:0] er;
        int          ec;
        er = exp_res.pop_front();
        ec = exp_cyc.pop_front();
        check("result", result, er);
        check("done_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  initial begin
    int c0;
    logic [1:0]  op;
    logic [31:0] a, b;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", result, 32'h0);

    // Release and start in the very first cycle.
    rst = 1'b0;
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    wait_idle(); issue(2'b11, 32'd100, 32'd7, 1'b1);
    wait_idle(); issue(2'b00, -32'sd7, 32'd2, 1'b1);
    wait_idle(); issue(2'b10, -32'sd7, 32'd2, 1'b1);
    wait_idle(); issue(2'b00, 32'd5, 32'd0, 1'b1);
    wait_idle(); issue(2'b10, 32'd5, 32'd0, 1'b1);
    wait_idle(); issue(2'b00, -32'sd5, 32'd0, 1'b1);
    wait_idle(); issue(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b1);
    wait_idle(); issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(); issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(); issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Start while busy must not disturb the in-flight op.
    wait_idle();
    c0 = cyc;
    issue(2'b01, 32'd1000, 32'd10, 1'b1);
    wait_until(c0 + 10);
    issue(2'b00, 32'd7, 32'd0, 1'b0);
    drain();

    // Random traffic, mix of back-to-back and gaps.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       begin a = $urandom; b = 32'h0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = $urandom_range(0, 40); b = $urandom_range(1, 9);
                       if ($urandom_range(0, 1) == 1) a = -a;
                       if ($urandom_range(0, 1) == 1) b = -b; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b, 1'b1);
    end
    drain();

    // Flush: ignored second start at +10, flush at +20, nothing may complete.
    c0 = cyc;
    issue(2'b01, 32'd12345, 32'd17, 1'b0);
    wait_until(c0 + 10);
    issue(2'b00, 32'd99, 32'd3, 1'b0);
    wait_until(c0 + 20);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("flush_busy", 32'(busy), 32'h0);
      check("flush_result", result, last_exp);
      @(negedge clk);
    end

    // Asynchronous reset mid-operation, then a fresh op right after release.
    c0 = cyc;
    issue(2'b01, 32'd5000, 32'd7, 1'b0);
    wait_until(c0 + 15);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b01, 32'd9, 32'd3, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
